// File: rtl/spi_vcmd_if.sv
// Host-side bus of the video command decoder: SPI pins in, byte and pixel-write strobes out.
interface spi_vcmd_if #(
  parameter int ADDR_W = 18
);
  logic              Sclk;
  logic              Mosi;
  logic              CSel;
  logic              DataRecv;
  logic [7:0]        RxData;
  logic [ADDR_W-1:0] MemAddr;
  logic [7:0]        DataOut;
  logic [1:0]        DataIndex;
  logic              DataRdy;

  modport slave (
    input  Sclk, Mosi, CSel,
    output DataRecv, RxData, MemAddr, DataOut, DataIndex, DataRdy
  );

  modport master (
    output Sclk, Mosi, CSel,
    input  DataRecv, RxData, MemAddr, DataOut, DataIndex, DataRdy
  );
endinterface

// File: rtl/spi_vcmd.sv
// SPI slave byte receiver feeding a set-address / pixel-write command decoder.
// Everything runs on Clk; SPI pins are synchronised and Sclk falling edges detected.
module spi_vcmd #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 18
) (
  input  logic         Clk,
  input  logic         RstN,
  spi_vcmd_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR0, S_WR1, S_WR2, S_SA0, S_SA1, S_SA2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_csel_sync;
  logic                   r_sclk_prev;
  logic                   w_sclk_fall;
  logic                   w_mosi;
  logic                   w_csel;

  logic [2:0]             r_bit_cnt;
  logic [6:0]             r_shift;
  logic                   r_data_recv;
  logic [7:0]             r_rx_data;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [ADDR_W-1:0]      r_addr;
  logic [ADDR_W-1:0]      w_addr_next;
  logic [5:0]             r_stride;
  logic [5:0]             w_stride_next;
  logic [ADDR_W-7:0]      r_sa_acc;
  logic [ADDR_W-7:0]      w_sa_next;
  logic                   w_wr;
  logic [1:0]             w_idx;

  logic [ADDR_W-1:0]      r_mem_addr;
  logic [7:0]             r_data_out;
  logic [1:0]             r_data_index;
  logic                   r_data_rdy;

  assign w_sclk_fall = r_sclk_prev & ~r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_csel      = r_csel_sync[SYNC_STAGES-1];

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_csel_sync <= '0;
      r_sclk_prev <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.Sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.Mosi};
      r_csel_sync <= {r_csel_sync[SYNC_STAGES-2:0], bus.CSel};
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
    end
  end

  // Deselect discards any partial byte, so a frame cut short never pulses DataRecv.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_bit_cnt   <= 3'd0;
      r_shift     <= 7'd0;
      r_data_recv <= 1'b0;
      r_rx_data   <= 8'd0;
    end else begin
      r_data_recv <= 1'b0;
      if (w_csel) begin
        r_bit_cnt <= 3'd0;
        r_shift   <= 7'd0;
      end else if (w_sclk_fall) begin
        r_shift <= {r_shift[5:0], w_mosi};
        if (r_bit_cnt == 3'd7) begin
          r_rx_data   <= {r_shift, w_mosi};
          r_data_recv <= 1'b1;
          r_bit_cnt   <= 3'd0;
        end else begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_addr_next   = r_addr;
    w_stride_next = r_stride;
    w_sa_next     = r_sa_acc;
    w_wr          = 1'b0;
    w_idx         = 2'd0;
    if (r_data_recv) begin
      case (r_state)
        S_IDLE: begin
          if (r_rx_data[7:6] == 2'b01) begin
            w_state_next  = S_WR0;
            w_stride_next = r_rx_data[5:0];
          end else if (r_rx_data[7:6] == 2'b10) begin
            w_state_next = S_SA0;
          end
        end
        S_WR0: begin
          w_wr         = 1'b1;
          w_idx        = 2'd0;
          w_state_next = S_WR1;
        end
        S_WR1: begin
          w_wr         = 1'b1;
          w_idx        = 2'd1;
          w_state_next = S_WR2;
        end
        S_WR2: begin
          // Write uses the pre-increment address; the stride applies to the next pixel.
          w_wr         = 1'b1;
          w_idx        = 2'd2;
          w_addr_next  = r_addr + {{(ADDR_W-6){1'b0}}, r_stride};
          w_state_next = S_IDLE;
        end
        S_SA0: begin
          w_sa_next[ADDR_W-7 -: 6] = r_rx_data[5:0];
          w_state_next             = S_SA1;
        end
        S_SA1: begin
          w_sa_next[5:0] = r_rx_data[5:0];
          w_state_next   = S_SA2;
        end
        S_SA2: begin
          w_addr_next  = {r_sa_acc, r_rx_data[5:0]};
          w_state_next = S_IDLE;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_stride     <= 6'd0;
      r_sa_acc     <= '0;
      r_mem_addr   <= '0;
      r_data_out   <= 8'd0;
      r_data_index <= 2'd0;
      r_data_rdy   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_addr     <= w_addr_next;
      r_stride   <= w_stride_next;
      r_sa_acc   <= w_sa_next;
      r_data_rdy <= w_wr;
      if (w_wr) begin
        r_mem_addr   <= r_addr;
        r_data_out   <= r_rx_data;
        r_data_index <= w_idx;
      end
    end
  end

  assign bus.DataRecv  = r_data_recv;
  assign bus.RxData    = r_rx_data;
  assign bus.MemAddr   = r_mem_addr;
  assign bus.DataOut   = r_data_out;
  assign bus.DataIndex = r_data_index;
  assign bus.DataRdy   = r_data_rdy;

endmodule

// File: tb/tb_spi_vcmd.sv
// Directed bench for spi_vcmd: drives SPI frames and checks received bytes and pixel-write strobes.
module tb_spi_vcmd;

  logic Clk;
  logic RstN;
  int   n_tests;
  int   n_fail;
  logic prev_recv;

  typedef struct {
    logic [17:0] a;
    logic [7:0]  d;
    logic [1:0]  i;
  } wr_t;

  logic [7:0] rx_q[$];
  wr_t        wr_q[$];

  spi_vcmd_if #(.ADDR_W(18)) bus ();

  spi_vcmd #(.SYNC_STAGES(2), .ADDR_W(18)) dut (
    .Clk  (Clk),
    .RstN (RstN),
    .bus  (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s got %h want %h", tag, obs, expv);
    end
  endtask

  // Capture every strobe so pulse counts and latency are checked, not just contents.
  initial prev_recv = 1'b0;
  always @(negedge Clk) begin
    if (bus.DataRecv === 1'b1) rx_q.push_back(bus.RxData);
    if (bus.DataRdy === 1'b1) begin
      wr_q.push_back('{a: bus.MemAddr, d: bus.DataOut, i: bus.DataIndex});
      chk("rdy_latency", {31'd0, prev_recv}, 32'd1);
    end
    prev_recv = bus.DataRecv;
  end

  task automatic spi_byte(input logic [7:0] b);
    bus.CSel = 1'b0;
    #40;
    for (int k = 7; k >= 0; k--) begin
      bus.Mosi = b[k];
      bus.Sclk = 1'b1;
      #40;
      bus.Sclk = 1'b0;
      #40;
    end
    bus.CSel = 1'b1;
    #40;
  endtask

  task automatic spi_partial(input int nbits);
    bus.CSel = 1'b0;
    #40;
    for (int k = 0; k < nbits; k++) begin
      bus.Mosi = 1'b1;
      bus.Sclk = 1'b1;
      #40;
      bus.Sclk = 1'b0;
      #40;
    end
    bus.CSel = 1'b1;
    #100;
  endtask

  task automatic exp_rx(input logic [7:0] b);
    logic [7:0] got;
    if (rx_q.size() == 0) begin
      chk("rx_missing", 32'd0, 32'd1);
    end else begin
      got = rx_q.pop_front();
      $display("[TB] rx byte %h (want %h)", got, b);
      chk("rx_data", {24'd0, got}, {24'd0, b});
    end
  endtask

  task automatic exp_wr(input logic [17:0] a, input logic [7:0] d, input logic [1:0] i);
    wr_t w;
    if (wr_q.size() == 0) begin
      chk("wr_missing", 32'd0, 32'd1);
    end else begin
      w = wr_q.pop_front();
      $display("[TB] wr addr %h data %h idx %0d", w.a, w.d, w.i);
      chk("wr_addr", {14'd0, w.a}, {14'd0, a});
      chk("wr_data", {24'd0, w.d}, {24'd0, d});
      chk("wr_idx",  {30'd0, w.i}, {30'd0, i});
    end
  endtask

  task automatic exp_drained();
    chk("rx_extra", rx_q.size(), 32'd0);
    chk("wr_extra", wr_q.size(), 32'd0);
    rx_q.delete();
    wr_q.delete();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_recv"}, {31'd0, bus.DataRecv}, 32'd0);
    chk({tag, "_rx"},   {24'd0, bus.RxData}, 32'd0);
    chk({tag, "_addr"}, {14'd0, bus.MemAddr}, 32'd0);
    chk({tag, "_dout"}, {24'd0, bus.DataOut}, 32'd0);
    chk({tag, "_idx"},  {30'd0, bus.DataIndex}, 32'd0);
    chk({tag, "_rdy"},  {31'd0, bus.DataRdy}, 32'd0);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    RstN     = 1'b0;
    bus.Sclk = 1'b0;
    bus.Mosi = 1'b0;
    bus.CSel = 1'b1;
    #32;
    chk_outputs_zero("reset");
    @(negedge Clk);
    RstN = 1'b1;
    #50;

    // WRITE stride 1 at address 0
    spi_byte(8'h41); spi_byte(8'hC0); spi_byte(8'hC0); spi_byte(8'hC0);
    #200;
    exp_rx(8'h41); exp_rx(8'hC0); exp_rx(8'hC0); exp_rx(8'hC0);
    exp_wr(18'h0, 8'hC0, 2'd0); exp_wr(18'h0, 8'hC0, 2'd1); exp_wr(18'h0, 8'hC0, 2'd2);
    exp_drained();

    // address advanced by stride to 1
    spi_byte(8'h41); spi_byte(8'h03); spi_byte(8'h03); spi_byte(8'h03);
    #200;
    exp_wr(18'h1, 8'h03, 2'd0); exp_wr(18'h1, 8'h03, 2'd1); exp_wr(18'h1, 8'h03, 2'd2);
    rx_q.delete();
    exp_drained();

    // SETADDR to 0x3FFFF, then WRITE stride 2 wraps to 0x00001
    spi_byte(8'h80); spi_byte(8'h3F); spi_byte(8'h3F); spi_byte(8'h3F);
    #200;
    exp_rx(8'h80); exp_rx(8'h3F); exp_rx(8'h3F); exp_rx(8'h3F);
    exp_drained();
    spi_byte(8'h42); spi_byte(8'h11); spi_byte(8'h22); spi_byte(8'h33);
    #200;
    exp_wr(18'h3FFFF, 8'h11, 2'd0); exp_wr(18'h3FFFF, 8'h22, 2'd1); exp_wr(18'h3FFFF, 8'h33, 2'd2);
    rx_q.delete();
    exp_drained();

    // aborted partial byte, then a full WRITE at the wrapped address
    spi_partial(5);
    spi_byte(8'h41);
    #200;
    exp_rx(8'h41);
    exp_drained();
    spi_byte(8'h55); spi_byte(8'h66); spi_byte(8'h77);
    #200;
    exp_rx(8'h55); exp_rx(8'h66); exp_rx(8'h77);
    exp_wr(18'h1, 8'h55, 2'd0); exp_wr(18'h1, 8'h66, 2'd1); exp_wr(18'h1, 8'h77, 2'd2);
    exp_drained();

    // NOP and reserved opcode: bytes received, nothing written, outputs held
    spi_byte(8'h00); spi_byte(8'hC5);
    #200;
    exp_rx(8'h00); exp_rx(8'hC5);
    exp_drained();
    chk("hold_addr", {14'd0, bus.MemAddr}, 32'h1);
    chk("hold_dout", {24'd0, bus.DataOut}, 32'h77);
    chk("hold_idx",  {30'd0, bus.DataIndex}, 32'd2);

    // FSM was still in IDLE: 0x41 starts a packet at address 2
    spi_byte(8'h41); spi_byte(8'hAA);
    #200;
    exp_wr(18'h2, 8'hAA, 2'd0);
    rx_q.delete();
    exp_drained();

    // asynchronous reset mid-packet
    #3;
    RstN = 1'b0;
    #2;
    chk_outputs_zero("midrst");
    @(negedge Clk);
    RstN = 1'b1;
    #50;
    spi_byte(8'h41); spi_byte(8'h01); spi_byte(8'h02); spi_byte(8'h03);
    #200;
    exp_rx(8'h41); exp_rx(8'h01); exp_rx(8'h02); exp_rx(8'h03);
    exp_wr(18'h0, 8'h01, 2'd0); exp_wr(18'h0, 8'h02, 2'd1); exp_wr(18'h0, 8'h03, 2'd2);
    exp_drained();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout got 1 want 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_vcmd.md
Name: spi_vcmd

Overview:
- SPI slave receiver plus video command decoder for the VGA controller's host interface.
- Receives MSB-first bytes on Sclk/Mosi framed by an active-low CSel. Bytes are decoded into set-address and pixel-write packets.
- Pixel-write packets are presented to the frame-memory writer as (MemAddr, DataOut, DataIndex, DataRdy) strobes.
- All logic runs in the Clk domain; SPI pins are synchronised and edge-detected.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on the Sclk/Mosi/CSel inputs (≥2).
- ADDR_W, 18, memory address width; must equal 3×6.

Ports:
- Clk  in  1  system clock, rising edge; frequency ≥ 4× Sclk.
- RstN  in  1  asynchronous active-low reset.
- Sclk  in  1  SPI clock, idle low, asynchronous to Clk.
- Mosi  in  1  SPI data; valid while Sclk high; sampled at Sclk falling edge.
- CSel  in  1  active-low chip select; frames each byte.
- DataRecv  out  1  one-Clk pulse when a full byte is received.
- RxData  out  8  last received byte; valid with DataRecv and held after.
- MemAddr  out  ADDR_W  pixel address of the current write.
- DataOut  out  8  data byte for the current write.
- DataIndex  out  2  component index 0..2 of the current write.
- DataRdy  out  1  one-Clk write strobe.

Behaviour:
- Reset (RstN low, asynchronous): every output and internal register clears to 0. The command FSM goes to IDLE, the address register to 0, and the bit counter to 0.
- Synchronise Sclk, Mosi and CSel through SYNC_STAGES flops. Detect an Sclk falling edge as previous=1, current=0.
- SPI receiver:
  - While synced CSel is high, the bit counter is held at 0 and the partial shift register is discarded.
  - While CSel is low, each Sclk falling edge shifts Mosi into the LSB; the first bit received becomes the MSB.
  - On the 8th bit: RxData takes the byte, DataRecv pulses high for exactly one Clk, and the counter returns to 0.
  - CSel rising mid-byte drops the partial byte and produces no pulse.
  - Multiple bytes under one continuous CSel low are accepted.
- Command byte layout: [7:6] opcode, [5:0] argument.
  - 00 NOP: no payload; stays in IDLE.
  - 01 WRITE: 3 payload bytes follow; arg is the address stride.
  - 10 SETADDR: 3 payload bytes follow; each contributes its [5:0].
  - 11 reserved: treated as NOP.
- FSM states: IDLE, WR0, WR1, WR2, SA0, SA1, SA2. Advance only on DataRecv.
  - IDLE → WR0 on opcode 01, latching stride = arg.
  - IDLE → SA0 on opcode 10.
  - WRk (k=0..2): the next byte produces a write. One Clk after DataRecv: DataOut = byte, DataIndex = k, MemAddr = address register, DataRdy = 1 for one Clk. WR0→WR1→WR2→IDLE.
  - On leaving WR2: address ← (address + stride) mod 2^18. Stride 0 rewrites the same location next time.
  - SAk: shift byte[5:0] into the address. SA0 gives bits [17:12], SA1 [11:6], SA2 [5:0]. The address register is updated only after SA2, which returns to IDLE. Byte [7:6] is ignored.
- MemAddr, DataOut and DataIndex hold their values between strobes.
- Latency: DataRdy occurs exactly 1 Clk after the DataRecv of the same byte. DataRecv occurs SYNC_STAGES+1 Clk after the Sclk falling edge.
- Packets are not aborted by CSel high between bytes; FSM state persists across frames.
- Only reset returns the FSM to IDLE mid-packet. The address register is also cleared by reset.
- Address wraps 0x3FFFF + stride → stride−1 (mod 2^18).

Test Plan:
- Reset, then send bytes 0x41, 0xC0, 0xC0, 0xC0, each in its own CSel frame. Required:
  - 4 DataRecv pulses with RxData 0x41, 0xC0, 0xC0, 0xC0.
  - 3 DataRdy strobes, MemAddr=0, DataOut=0xC0, DataIndex=0,1,2.
- Continue with 0x41, 0x03, 0x03, 0x03 → 3 strobes at MemAddr=1, DataOut=0x03, DataIndex=0,1,2.
- Send 0x80, 0x3F, 0x3F, 0x3F, then 0x42, 0x11, 0x22, 0x33. Required:
  - Strobes at MemAddr=0x3FFFF with data 0x11/0x22/0x33.
  - Internal address then wraps to 0x00001; the next WRITE strobes at MemAddr=1.
- Raise CSel after 5 bits, then send a full 0x41 → no DataRecv for the partial byte; one DataRecv with RxData=0x41.
- Send 0x00, 0xC5 → DataRecv pulses but no DataRdy; FSM remains in IDLE.
- Assert RstN low after 0x41, 0xAA → all outputs 0. A following 0x41, 0x01, 0x02, 0x03 writes at MemAddr=0 with DataIndex starting at 0.
